var_rate_counter: RTL and testbench
===================================

VAR_RATE_COUNTER -- requirements
Module: var_rate_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 4, count width.
REQ-002 SHALL have parameter MAX_CNT, default 9, wrap value (MAX_CNT < 2**CNT_W).
REQ-003 SHALL have parameter LEVELS, default 4, number of speed levels (2..8).
REQ-004 SHALL have parameter DIV_BASE, default 50_000_000, clk cycles per tick at level 0 (DIV_BASE >> (LEVELS-1) >= 1).
REQ-005 SHALL have parameter RST_LEVEL, default 0, level after reset.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port pause_btn, input, 1, async button; a rising edge toggles run/pause.
REQ-009 SHALL have port faster_btn, input, 1, async button; a rising edge increments the level.
REQ-010 SHALL have port slower_btn, input, 1, async button; a rising edge decrements the level.
REQ-011 SHALL have port dir, input, 1, count direction (0 up, 1 down); sampled at every tick.
REQ-012 SHALL have port clr, input, 1, synchronous clear of count.
REQ-013 SHALL have port count, output, CNT_W, current count.
REQ-014 SHALL have port level, output, clog2(LEVELS), current speed level.
REQ-015 SHALL have port running, output, 1, high in RUN.
REQ-016 SHALL have port tick, output, 1, one-cycle pulse on each count step.

Function
REQ-017 SHALL pass each button through a 2-flop synchronizer, then a registered rising-edge detector, producing a 1-cycle pulse; the effect SHALL be visible on outputs 3 clk edges after the input rises.
REQ-018 SHALL implement FSM states PAUSED and RUN; a pause pulse toggles the state; there are no other transitions.
REQ-019 SHALL set tick period P = DIV_BASE >> level cycles; the prescaler counts 0..P-1 in RUN and asserts tick in the cycle it equals P-1.
REQ-020 SHALL hold the prescaler at 0 in PAUSED and clear it on any level change, giving a full new period after resume or level change.
REQ-021 SHALL step count on tick by +1 (dir=0) or -1 (dir=1); up wraps MAX_CNT->0; down wraps 0->MAX_CNT.
REQ-022 SHALL saturate on faster at level LEVELS-1 and on slower at level 0.
REQ-023 SHALL leave the level unchanged when faster and slower pulses coincide.
REQ-024 SHALL, on clr, force count=0 next cycle, overriding a coincident tick; state, level and prescaler SHALL be unaffected.
REQ-025 SHALL accept level changes in both PAUSED and RUN.
REQ-026 SHALL drive all outputs from registers, except tick, which is a registered pulse aligned with the count update.

Reset
REQ-027 SHALL, with rst high at a clk edge, set: count=0, level=RST_LEVEL, state PAUSED, running=0, tick=0, prescaler=0, synchronizer/edge flops=0.
REQ-028 SHALL give rst priority over all inputs; rst mid-run SHALL abort the period, and a button held through reset SHALL NOT generate a pulse after release of rst.

Structure
REQ-029 SHALL place state encoding (PAUSED/RUN) and the level-width helper constant in a shared package var_rate_pkg.
REQ-030 SHALL use one sub-module, btn_edge (2-flop sync + rising-edge pulse), instantiated three times.

Verification (CNT_W=4, MAX_CNT=9, LEVELS=4, DIV_BASE=16, RST_LEVEL=0)
REQ-031 SHALL verify reset and pause: rst 2 cycles, then 100 cycles idle -> count=0, running=0, tick never asserted.
REQ-032 SHALL verify run rate: pause pulse -> running=1 after 3 edges; ticks every 16 cycles; count 0..9 then wraps to 0 on the 10th tick.
REQ-033 SHALL verify speed levels: 3 faster pulses -> level=3, tick period 2; a 4th faster pulse -> level stays 3; slower pulse -> level 2, period 4.
REQ-034 SHALL verify down count: dir=1 from count=0 -> next tick count=9, then 8.
REQ-035 SHALL verify clr and simultaneous events: clr coincident with tick -> count=0; coincident faster+slower pulses -> level unchanged.
REQ-036 SHALL verify reset mid-run: rst asserted at count=5, level=2, RUN -> count=0, level=0, PAUSED; pause_btn held high through reset -> no toggle after release.

Source files
------------

// File: rtl/var_rate_pkg.sv
// Shared definitions for the variable-rate counter: run/pause state
// encoding and the helper that sizes the speed-level field.
package var_rate_pkg;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } run_state_e;

    // Smallest legal level field is one bit, even for two levels.
    localparam int MIN_LVL_W = 1;

    function automatic int lvl_width(input int levels);
        return (levels <= 2) ? MIN_LVL_W : $clog2(levels);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector. The output pulse is one clock wide and is qualified
// by an "armed" flag that only sets once the synchronized button has been
// seen low after reset, so a button held through reset never fires.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic valid1_q;
    logic valid2_q;
    logic armed_q;

    // Synchronize the button, remember its last value and arm once it is seen released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            valid1_q <= 1'b1;
            valid2_q <= valid1_q;
            if (valid2_q && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pulse_o = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/var_rate_counter.sv
// Variable-rate up/down counter. Three buttons toggle run/pause and step the
// speed level; the tick period is DIV_BASE >> level clocks. Count wraps
// between 0 and MAX_CNT in either direction and can be cleared at any time.
module var_rate_counter
    import var_rate_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int MAX_CNT   = 9,
    parameter int LEVELS    = 4,
    parameter int DIV_BASE  = 50_000_000,
    parameter int RST_LEVEL = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pause_btn,
    input  logic                             faster_btn,
    input  logic                             slower_btn,
    input  logic                             dir,
    input  logic                             clr,
    output logic [CNT_W-1:0]                 count,
    output logic [lvl_width(LEVELS)-1:0]     level,
    output logic                             running,
    output logic                             tick
);

    localparam int LVL_W = lvl_width(LEVELS);
    localparam int PRE_W = $clog2(DIV_BASE + 1);

    localparam logic [PRE_W-1:0] DIV_VEC = PRE_W'(DIV_BASE);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(RST_LEVEL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);

    logic pause_p;
    logic faster_p;
    logic slower_p;

    run_state_e       state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    logic [PRE_W-1:0] period_last;
    logic             level_chg;
    logic             step_now;

    btn_edge u_pause (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (pause_btn),
        .pulse_o (pause_p)
    );

    btn_edge u_faster (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (faster_btn),
        .pulse_o (faster_p)
    );

    btn_edge u_slower (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (slower_btn),
        .pulse_o (slower_p)
    );

    // Run/pause state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    // A pause pulse is the only thing that moves the state machine.
    always_comb begin
        state_d = state_q;
        if (pause_p) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end
    end

    // Running flag decoded straight from the state flop.
    always_comb begin
        running = (state_q == RUN);
    end

    // Level steps up or down with saturation; simultaneous requests cancel.
    always_comb begin
        level_d = level_q;
        if (faster_p && !slower_p && (level_q != LVL_MAX)) begin
            level_d = level_q + LVL_W'(1);
        end else if (slower_p && !faster_p && (level_q != '0)) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    assign period_last = PRE_W'((DIV_VEC >> level_q) - PRE_W'(1));
    assign level_chg   = (level_d != level_q);
    assign step_now    = (state_q == RUN) && !level_chg && (pre_q == period_last);

    // Prescaler restarts after pause, resume, level change and each tick; count steps on tick.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if ((state_q != RUN) || (state_d != RUN) || level_chg || step_now) begin
            pre_d = '0;
        end

        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (step_now) begin
            if (dir) begin
                count_d = (count_q == '0) ? CNT_MAX : count_q - CNT_W'(1);
            end else begin
                count_d = (count_q == CNT_MAX) ? '0 : count_q + CNT_W'(1);
            end
        end

        tick_d = step_now;
    end

    // Datapath registers: level, prescaler, count and the tick pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= LVL_RST;
            pre_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign count = count_q;
    assign level = level_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_var_rate_counter.sv
// Directed testbench for var_rate_counter with DIV_BASE=16, four levels and
// a 0..9 count range. Inputs change and outputs are sampled 1ns after each
// rising clock edge.
module tb_var_rate_counter;

    localparam int SEL_PAUSE  = 0;
    localparam int SEL_FASTER = 1;
    localparam int SEL_SLOWER = 2;
    localparam int TICK_LIMIT = 200;

    logic       clk;
    logic       rst;
    logic       pause_btn;
    logic       faster_btn;
    logic       slower_btn;
    logic       dir;
    logic       clr;
    logic [3:0] count;
    logic [1:0] level;
    logic       running;
    logic       tick;

    int compared   = 0;
    int mismatched = 0;

    var_rate_counter #(
        .CNT_W     (4),
        .MAX_CNT   (9),
        .LEVELS    (4),
        .DIV_BASE  (16),
        .RST_LEVEL (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause_btn  (pause_btn),
        .faster_btn (faster_btn),
        .slower_btn (slower_btn),
        .dir        (dir),
        .clr        (clr),
        .count      (count),
        .level      (level),
        .running    (running),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic tickClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
            $error("[TB] %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Hold a button high for three edges, then release and let it settle.
    task automatic applyStimulus(input int sel);
        case (sel)
            SEL_PAUSE:  pause_btn  = 1'b1;
            SEL_FASTER: faster_btn = 1'b1;
            default:    slower_btn = 1'b1;
        endcase
        tickClk(3);
        pause_btn  = 1'b0;
        faster_btn = 1'b0;
        slower_btn = 1'b0;
        tickClk(3);
    endtask

    // Count edges until tick is seen, giving up after a fixed budget.
    task automatic waitTick(output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int k = 0; k < TICK_LIMIT && !found; k++) begin
            tickClk(1);
            cycles++;
            if (tick) found = 1'b1;
        end
        checkOutput("tick_within_budget", found, 1);
    endtask

    initial begin
        int   cyc;
        logic sawTick;

        rst        = 1'b1;
        pause_btn  = 1'b0;
        faster_btn = 1'b0;
        slower_btn = 1'b0;
        dir        = 1'b0;
        clr        = 1'b0;

        // Reset, then idle while paused.
        tickClk(2);
        rst = 1'b0;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_tick", tick, 0);
        sawTick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tickClk(1);
            sawTick = sawTick | tick;
        end
        checkOutput("idle_no_tick", sawTick, 0);
        checkOutput("idle_count", count, 0);
        checkOutput("idle_running", running, 0);

        // Start running: visible on the third edge after the press.
        pause_btn = 1'b1;
        tickClk(2);
        checkOutput("run_after_2_edges", running, 0);
        tickClk(1);
        checkOutput("run_after_3_edges", running, 1);
        pause_btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            waitTick(cyc);
            checkOutput("level0_period", cyc, 16);
            checkOutput("up_count", count, i % 10);
        end

        // Pause, then raise the level to the top and beyond.
        applyStimulus(SEL_PAUSE);
        checkOutput("paused_running", running, 0);
        checkOutput("paused_count", count, 0);
        applyStimulus(SEL_FASTER);
        checkOutput("faster_1", level, 1);
        applyStimulus(SEL_FASTER);
        checkOutput("faster_2", level, 2);
        applyStimulus(SEL_FASTER);
        checkOutput("faster_3", level, 3);
        applyStimulus(SEL_FASTER);
        checkOutput("faster_saturate", level, 3);

        // Resume at level 3 and measure, then slow down to level 2.
        applyStimulus(SEL_PAUSE);
        checkOutput("resume_running", running, 1);
        waitTick(cyc);
        waitTick(cyc);
        checkOutput("level3_period", cyc, 2);
        applyStimulus(SEL_SLOWER);
        checkOutput("slower_level", level, 2);
        waitTick(cyc);
        waitTick(cyc);
        checkOutput("level2_period", cyc, 4);

        // Down count from zero wraps to nine, then eight.
        applyStimulus(SEL_PAUSE);
        checkOutput("pause_again", running, 0);
        clr = 1'b1;
        tickClk(1);
        clr = 1'b0;
        checkOutput("clr_paused", count, 0);
        checkOutput("clr_keeps_level", level, 2);
        dir = 1'b1;
        applyStimulus(SEL_PAUSE);
        waitTick(cyc);
        checkOutput("down_wrap", count, 9);
        waitTick(cyc);
        checkOutput("down_period", cyc, 4);
        checkOutput("down_step", count, 8);

        // Clear on the same edge as a tick wins over the step.
        tickClk(3);
        clr = 1'b1;
        tickClk(1);
        clr = 1'b0;
        checkOutput("clr_tick_pulse", tick, 1);
        checkOutput("clr_over_tick", count, 0);
        checkOutput("clr_keeps_running", running, 1);

        // Faster and slower together leave the level alone.
        faster_btn = 1'b1;
        slower_btn = 1'b1;
        tickClk(3);
        faster_btn = 1'b0;
        slower_btn = 1'b0;
        tickClk(3);
        checkOutput("both_buttons_level", level, 2);

        // Count up to five, then reset mid-run with pause held.
        dir = 1'b0;
        clr = 1'b1;
        tickClk(1);
        clr = 1'b0;
        checkOutput("clr_running", count, 0);
        for (int i = 0; i < 5; i++) waitTick(cyc);
        checkOutput("prereset_count", count, 5);
        checkOutput("prereset_level", level, 2);
        checkOutput("prereset_running", running, 1);
        pause_btn = 1'b1;
        rst       = 1'b1;
        tickClk(2);
        rst = 1'b0;
        checkOutput("midrun_reset_count", count, 0);
        checkOutput("midrun_reset_level", level, 0);
        checkOutput("midrun_reset_running", running, 0);
        checkOutput("midrun_reset_tick", tick, 0);
        tickClk(10);
        checkOutput("held_btn_no_toggle", running, 0);
        pause_btn = 1'b0;
        tickClk(10);
        checkOutput("release_no_toggle", running, 0);
        applyStimulus(SEL_PAUSE);
        checkOutput("post_reset_press", running, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
